// File: rtl/pri_encode_scan.sv
// Sequential priority scanner: accepts a request vector and emits the index of
// every set bit, one beat per handshake, in MSB-first or LSB-first order.
//
// state | meaning
// IDLE  | no vector held; in_ready follows en
// SCAN  | emitting indices from r_mask (or a single out_none beat)
module pri_encode_scan #(
   parameter int WIDTH     = 8,
   parameter int IDXW      = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             idc,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] w_mask_nxt;
   logic [WIDTH-1:0] w_sel_bit;
   logic             r_none;
   logic             w_none_nxt;
   logic [IDXW-1:0]  w_idx;
   logic             w_single;
   logic             w_accept;
   logic             w_beat;

   // Later matches overwrite earlier ones, so the scan direction picks priority.
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (MSB_FIRST) begin
            if (r_mask[i]) begin
               w_idx = IDXW'(i);
            end
         end else begin
            if (r_mask[WIDTH-1-i]) begin
               w_idx = IDXW'(WIDTH-1-i);
            end
         end
      end
   end

   assign w_sel_bit = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;
   assign w_single  = (r_mask != '0) && ((r_mask & (r_mask - WIDTH'(1))) == '0);

   assign out_valid = (r_state == SCAN);
   assign out_idx   = w_idx;
   assign out_last  = out_valid && (w_single || r_none);
   assign out_none  = out_valid && r_none;
   assign idc       = out_valid && !r_none;
   assign busy      = out_valid;

   // A new vector may follow the final beat of the current one with no bubble.
   assign in_ready  = rst_n && en && ((r_state == IDLE) || (out_ready && out_last));
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_beat    = out_valid && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_none_nxt  = r_none;
      if (flush) begin
         w_state_nxt = IDLE;
         w_mask_nxt  = '0;
         w_none_nxt  = 1'b0;
      end else if (w_accept) begin
         w_state_nxt = SCAN;
         w_mask_nxt  = in_data;
         w_none_nxt  = (in_data == '0);
      end else if (w_beat) begin
         w_mask_nxt = r_mask & ~w_sel_bit;
         if (out_last) begin
            w_state_nxt = IDLE;
            w_none_nxt  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_none  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_none  <= w_none_nxt;
      end
   end

endmodule

// File: tb/tb_pri_encode_scan.sv
// Bench for pri_encode_scan: three instances (8-bit MSB-first, 8-bit LSB-first,
// 16-bit MSB-first) checked every cycle against a queue-of-beats model.
module tb_pri_encode_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        v_rdy [3];
   logic        v_val [3];
   logic        v_last[3];
   logic        v_none[3];
   logic        v_idc [3];
   logic        v_busy[3];
   logic [2:0]  idx0, idx1;
   logic [3:0]  idx2;

   int total = 0;
   int bad   = 0;
   // Beat encoding: idx + 256*last + 512*none
   int q0[$], q1[$], q2[$];

   pri_encode_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(v_rdy[0]), .in_data(in_data[7:0]), .out_valid(v_val[0]),
      .out_ready(out_ready), .out_idx(idx0), .out_last(v_last[0]),
      .out_none(v_none[0]), .idc(v_idc[0]), .busy(v_busy[0]));

   pri_encode_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(v_rdy[1]), .in_data(in_data[7:0]), .out_valid(v_val[1]),
      .out_ready(out_ready), .out_idx(idx1), .out_last(v_last[1]),
      .out_none(v_none[1]), .idc(v_idc[1]), .busy(v_busy[1]));

   pri_encode_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(v_rdy[2]), .in_data(in_data), .out_valid(v_val[2]),
      .out_ready(out_ready), .out_idx(idx2), .out_last(v_last[2]),
      .out_none(v_none[2]), .idc(v_idc[2]), .busy(v_busy[2]));

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int didx(input int k);
      if (k == 0) return int'(idx0);
      if (k == 1) return int'(idx1);
      return int'(idx2);
   endfunction

   function automatic int qsize(input int k);
      if (k == 0) return q0.size();
      if (k == 1) return q1.size();
      return q2.size();
   endfunction

   function automatic int qhead(input int k);
      if (k == 0) return q0[0];
      if (k == 1) return q1[0];
      return q2[0];
   endfunction

   task automatic qpush(input int k, input int e);
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic qpop(input int k);
      int d;
      if (k == 0) d = q0.pop_front();
      else if (k == 1) d = q1.pop_front();
      else d = q2.pop_front();
   endtask

   task automatic qclear(input int k);
      if (k == 0) q0.delete();
      else if (k == 1) q1.delete();
      else q2.delete();
   endtask

   // Expand an accepted vector into its list of beats, in priority order.
   task automatic push_vec(input int k, input logic [15:0] v);
      int lst[$];
      int w;
      w = (k == 2) ? 16 : 8;
      if (k == 1) begin
         for (int i = 0; i < w; i++) if (v[i]) lst.push_back(i);
      end else begin
         for (int i = w - 1; i >= 0; i--) if (v[i]) lst.push_back(i);
      end
      if (lst.size() == 0) qpush(k, 256 + 512);
      for (int j = 0; j < lst.size(); j++)
         qpush(k, lst[j] + ((j == lst.size() - 1) ? 256 : 0));
   endtask

   // Compare all outputs with the model, then advance the model across one edge.
   task automatic cycle();
      bit acc[3];
      int hd, has, lst, non, rdy;
      #1;
      for (int k = 0; k < 3; k++) begin
         has = (qsize(k) > 0) ? 1 : 0;
         hd  = (has != 0) ? qhead(k) : 0;
         lst = (hd >> 8) & 1;
         non = (hd >> 9) & 1;
         rdy = (rst_n && en && (has == 0 || (out_ready && lst == 1))) ? 1 : 0;
         chk($sformatf("out_valid[%0d]", k), int'(v_val[k]), has);
         chk($sformatf("out_idx[%0d]", k), didx(k), hd % 256);
         chk($sformatf("out_last[%0d]", k), int'(v_last[k]), lst);
         chk($sformatf("out_none[%0d]", k), int'(v_none[k]), non);
         chk($sformatf("idc[%0d]", k), int'(v_idc[k]), (has != 0 && non == 0) ? 1 : 0);
         chk($sformatf("busy[%0d]", k), int'(v_busy[k]), has);
         chk($sformatf("in_ready[%0d]", k), int'(v_rdy[k]), rdy);
         acc[k] = in_valid && (rdy != 0) && !flush;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (qsize(k) > 0 && out_ready) qpop(k);
         if (flush) qclear(k);
         if (acc[k]) push_vec(k, in_data);
      end
   endtask

   task automatic drive(input bit iv, input logic [15:0] d, input bit e,
                        input bit orr, input bit fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      en        = e;
      out_ready = orr;
      flush     = fl;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; in_data = '0;
      #12;
      chk("rst out_valid", int'(v_val[0]), 0);
      chk("rst in_ready", int'(v_rdy[0]), 0);
      chk("rst busy", int'(v_busy[2]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // MSB/LSB order on 8'hA2, then a zero vector on the final beat
      drive(1, 16'h00A2, 1, 1, 0); cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t1 idx beat0", int'(idx0), 7);
      chk("t1 last beat0", int'(v_last[0]), 0);
      chk("t1 idc beat0", int'(v_idc[0]), 1);
      chk("t2 lsb idx beat0", int'(idx1), 1);
      cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t1 idx beat1", int'(idx0), 5);
      chk("t2 lsb idx beat1", int'(idx1), 5);
      cycle();
      drive(1, 16'h0000, 1, 1, 0); #1;
      chk("t1 idx beat2", int'(idx0), 1);
      chk("t1 last beat2", int'(v_last[0]), 1);
      chk("t1 in_ready last", int'(v_rdy[0]), 1);
      chk("t2 lsb idx beat2", int'(idx1), 7);
      cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t2 none", int'(v_none[1]), 1);
      chk("t2 none idx", int'(idx1), 0);
      chk("t2 none last", int'(v_last[1]), 1);
      chk("t2 none idc", int'(v_idc[1]), 0);
      cycle();

      // Backpressure on 8'h81
      drive(1, 16'h0081, 1, 0, 0); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(0, 16'h0055, 1, 0, 0); #1;
         chk("t3 held idx", int'(idx0), 7);
         chk("t3 held last", int'(v_last[0]), 0);
         cycle();
      end
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t3 beat0", int'(idx0), 7);
      cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t3 beat1", int'(idx0), 0);
      chk("t3 beat1 last", int'(v_last[0]), 1);
      cycle();

      // en=0 blocks acceptance; flush aborts an 8'hFF scan after two beats
      drive(1, 16'h000F, 0, 1, 0); #1;
      chk("t4 en0 in_ready", int'(v_rdy[0]), 0);
      cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t4 en0 no accept", int'(v_val[0]), 0);
      cycle();
      drive(1, 16'h00FF, 1, 1, 0); cycle();
      drive(0, 16'h0000, 1, 1, 0); cycle();
      drive(0, 16'h0000, 1, 1, 0); cycle();
      drive(1, 16'h00F0, 1, 0, 1); cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t4 flush valid", int'(v_val[0]), 0);
      chk("t4 flush busy", int'(v_busy[0]), 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(0, 16'h0000, 1, 1, 0); cycle();
      end

      // Asynchronous reset mid-scan of 8'h3C
      drive(1, 16'h003C, 1, 1, 0); cycle();
      drive(0, 16'h0000, 1, 1, 0); cycle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 rst valid", int'(v_val[0]), 0);
      chk("t5 rst busy", int'(v_busy[0]), 0);
      chk("t5 rst idx", int'(idx0), 0);
      chk("t5 rst in_ready", int'(v_rdy[0]), 0);
      for (int k = 0; k < 3; k++) qclear(k);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5 release in_ready", int'(v_rdy[0]), 1);
      cycle();

      // 16-bit instance on 16'h8001
      drive(1, 16'h8001, 1, 1, 0); cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t6 idx15", int'(idx2), 15);
      chk("t6 last0", int'(v_last[2]), 0);
      cycle();
      drive(0, 16'h0000, 1, 1, 0); #1;
      chk("t6 idx0", int'(idx2), 0);
      chk("t6 last1", int'(v_last[2]), 1);
      cycle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if ($urandom_range(0, 7) == 0) d = '0;
         else if ($urandom_range(0, 3) == 0) d = d & 16'($urandom);
         drive($urandom_range(0, 1) == 1, d, $urandom_range(0, 4) != 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 32) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
